// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised synchronous FIFO.
package sync_fifo_param_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 32'd16;
  localparam int unsigned FIFO_DEPTH_DEF = 32'd16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 32'd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value >= 32'd2) && ((value & (value - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read with enable.
module fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register: holds its value unless a read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock circular-buffer FIFO: pointer/level control, status flags and sticky errors.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [clog2(DEPTH):0]       level,
  output logic [clog2(DEPTH):0]       free_slots,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (WIDTH < 1) begin : g_width_check
    $error("sync_fifo_param: WIDTH must be at least 1");
  end

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic        rd_valid_q, rd_valid_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic        full_s, empty_s, wr_acc_s, rd_acc_s, ram_we_s, ram_re_s;

  assign full_s   = (level_q == DEPTH_L);
  assign empty_s  = (level_q == '0);
  // A read at full frees the slot the write lands in, so both can proceed.
  assign rd_acc_s = rd_en & ~empty_s;
  assign wr_acc_s = wr_en & (~full_s | rd_acc_s);
  assign ram_we_s = wr_acc_s & ~flush;
  assign ram_re_s = rd_acc_s & ~flush;

  // Next-state for pointers, level, read strobe and sticky errors; flush wins.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + ONE_L;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + ONE_L;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_d = level_q + ONE_L;
        2'b01:   level_d = level_q - ONE_L;
        default: level_d = level_q;
      endcase
      rd_valid_d  = rd_acc_s;
      overflow_d  = overflow_q | (wr_en & ~wr_acc_s);
      underflow_d = underflow_q | (rd_en & empty_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (ram_we_s),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (wr_data),
    .rd_en_i   (ram_re_s),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (level_q >= AF_L);
  assign almost_empty = (level_q <= AE_L);
  assign level        = level_q;
  assign free_slots   = DEPTH_L - level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at the default 16x16 configuration.
module tb_sync_fifo_param;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  level;
  logic [4:0]  free_slots;
  logic        overflow;
  logic        underflow;

  int vectors;
  int miscompares;

  sync_fifo_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .free_slots   (free_slots),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'h0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b exp 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b exp 0", full); end
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", level); end
    vectors++; if (free_slots !== 5'd16) begin miscompares++; $display("FAIL reset_free got %0d exp 16", free_slots); end
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_errors got %b exp 00", {overflow, underflow}); end
    vectors++; if ({almost_full, almost_empty} !== 2'b01) begin miscompares++; $display("FAIL reset_almost got %b exp 01", {almost_full, almost_empty}); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 16'(i);
      tick();
      vectors++; if (level !== 5'(i)) begin miscompares++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i); end
      vectors++; if (almost_full !== (i >= 14)) begin miscompares++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i >= 14)); end
      vectors++; if (full !== (i == 16)) begin miscompares++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 16)); end
      vectors++; if (free_slots !== 5'(16 - i)) begin miscompares++; $display("FAIL fill_free[%0d] got %0d exp %0d", i, free_slots, 16 - i); end
    end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fill_no_ovf got %b exp 0", overflow); end
    wr_data = 16'h0017;
    tick();
    wr_en = 1'b0;
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fill_ovf got %b exp 1", overflow); end
    vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL fill_ovf_level got %0d exp 16", level); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      tick();
      vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d] got %b exp 1", i, rd_valid); end
      vectors++; if (rd_data !== 16'(i)) begin miscompares++; $display("FAIL drain_data[%0d] got %h exp %h", i, rd_data, 16'(i)); end
      vectors++; if (level !== 5'(16 - i)) begin miscompares++; $display("FAIL drain_level[%0d] got %0d exp %0d", i, level, 16 - i); end
      vectors++; if (almost_empty !== ((16 - i) <= 2)) begin miscompares++; $display("FAIL drain_ae[%0d] got %b exp %b", i, almost_empty, ((16 - i) <= 2)); end
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b exp 1", empty); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL drain_no_unf got %b exp 0", underflow); end
    tick();
    rd_en = 1'b0;
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL drain_unf got %b exp 1", underflow); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL drain_unf_valid got %b exp 0", rd_valid); end
    vectors++; if (rd_data !== 16'h0010) begin miscompares++; $display("FAIL drain_hold got %h exp 0010", rd_data); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL drain_ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_simultaneous();
    do_flush();
    vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL simul_flush_err got %b exp 00", {overflow, underflow}); end
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 16'(16'h0100 + i);
      tick();
    end
    rd_en = 1'b1; wr_data = 16'hABCD;
    tick();
    wr_en = 1'b0;
    vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL simul_full_level got %0d exp 16", level); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL simul_full_ovf got %b exp 0", overflow); end
    vectors++; if (rd_data !== 16'h0101 || rd_valid !== 1'b1) begin miscompares++; $display("FAIL simul_full_data got %h/%b exp 0101/1", rd_data, rd_valid); end
    for (int i = 2; i <= 17; i++) begin
      tick();
      vectors++;
      if (rd_data !== ((i == 17) ? 16'hABCD : 16'(16'h0100 + i))) begin
        miscompares++; $display("FAIL simul_order[%0d] got %h exp %h", i, rd_data, ((i == 17) ? 16'hABCD : 16'(16'h0100 + i)));
      end
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL simul_drained got %b exp 1", empty); end
    wr_en = 1'b1; wr_data = 16'h5555;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    vectors++; if (level !== 5'd1) begin miscompares++; $display("FAIL simul_empty_level got %0d exp 1", level); end
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL simul_empty_unf got %b exp 1", underflow); end
    vectors++; if (rd_valid !== 1'b0 || rd_data !== 16'hABCD) begin miscompares++; $display("FAIL simul_empty_nobypass got %h/%b exp abcd/0", rd_data, rd_valid); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++; if (rd_data !== 16'h5555 || rd_valid !== 1'b1) begin miscompares++; $display("FAIL simul_empty_read got %h/%b exp 5555/1", rd_data, rd_valid); end
  endtask

  task automatic test_wrap();
    do_flush();
    for (int pass = 0; pass < 2; pass++) begin
      int n;
      n = (pass == 0) ? 10 : 12;
      for (int i = 0; i < n; i++) begin
        wr_en = 1'b1; wr_data = 16'(16'h0200 + 16'h0100 * pass + i);
        tick();
      end
      wr_en = 1'b0;
      vectors++; if (level !== 5'(n)) begin miscompares++; $display("FAIL wrap_level[%0d] got %0d exp %0d", pass, level, n); end
      for (int i = 0; i < n; i++) begin
        rd_en = 1'b1;
        tick();
        vectors++;
        if (rd_data !== 16'(16'h0200 + 16'h0100 * pass + i) || rd_valid !== 1'b1) begin
          miscompares++; $display("FAIL wrap_data[%0d.%0d] got %h exp %h", pass, i, rd_data, 16'(16'h0200 + 16'h0100 * pass + i));
        end
      end
      rd_en = 1'b0;
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty[%0d] got %b exp 1", pass, empty); end
    end
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 16'(16'h0400 + i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    vectors++; if (level !== 5'd5 || overflow !== 1'b1) begin miscompares++; $display("FAIL flush_setup got %0d/%b exp 5/1", level, overflow); end
    flush = 1'b1; wr_en = 1'b1; wr_data = 16'hDEAD;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    vectors++; if (level !== 5'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL flush_level got %0d/%b exp 0/1", level, empty); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL flush_ovf got %b exp 0", overflow); end
    vectors++; if (rd_valid !== 1'b0 || rd_data !== 16'h040A) begin miscompares++; $display("FAIL flush_hold got %h/%b exp 040a/0", rd_data, rd_valid); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++; if (rd_valid !== 1'b0 || underflow !== 1'b1) begin miscompares++; $display("FAIL flush_not_stored got %b/%b exp 0/1", rd_valid, underflow); end
  endtask

  task automatic test_reset_mid();
    do_flush();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 16'(16'h0600 + i);
      tick();
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b1; wr_en = 1'b1; wr_data = 16'h0700;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (level !== 5'd0 || empty !== 1'b1 || free_slots !== 5'd16) begin miscompares++; $display("FAIL rstmid_level got %0d/%b/%0d exp 0/1/16", level, empty, free_slots); end
    vectors++; if (rd_data !== 16'h0000 || rd_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_rd got %h/%b exp 0000/0", rd_data, rd_valid); end
    tick();
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL rstmid_hold got %0d exp 0", level); end
    wr_en = 1'b0; rd_en = 1'b0;
    #3 rst_n = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++; if (rd_valid !== 1'b0 || underflow !== 1'b1) begin miscompares++; $display("FAIL rstmid_no_commit got %b/%b exp 0/1", rd_valid, underflow); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
